// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 host driver.
//  - drv_state_t          : driver FSM state encoding
//  - WORDS_PER_BLOCK      : 16-bit load handshakes per 512-bit block
//  - HALFWORDS_PER_DIGEST : 16-bit fetch handshakes per 256-bit digest
//  - ABC_DIGEST           : SHA-256("abc"), a known-answer constant
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_REQ  = 3'd1,
    LD_WAIT = 3'd2,
    FT_REQ  = 3'd3,
    FT_GAP  = 3'd4,
    RALN    = 3'd5,
    FIN     = 3'd6,
    ERR     = 3'd7
  } drv_state_t;

  localparam int WORDS_PER_BLOCK      = 32;
  localparam int HALFWORDS_PER_DIGEST = 16;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

endpackage

// File: rtl/sha_hs_timeout.sv
// Loadable down-counter with an expiry flag.
// Used by the host driver both as the handshake timeout and as the
// post-load settle counter.
//  clk     in  clock, rising edge
//  rst     in  asynchronous active-high reset (counter clears to 0)
//  load    in  reload the counter with START (wins over en)
//  en      in  count down by one while the counter is non-zero
//  expired out counter has reached 0
module sha_hs_timeout #(
  parameter int START = 63,
  parameter int WIDTH = (START < 1) ? 1 : $clog2(START + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [WIDTH-1:0] cnt;

  // Reload has priority so that a restart on the same cycle as a
  // decrement always begins a full new interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= WIDTH'(START);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sha256_host_driver.sv
// Host-side master for the 16-bit load/fetch/ack SHA-256 peripheral port.
// Streams one 512-bit padded block as 32 big-endian 16-bit loads; on the
// last block of a message it fetches the digest as 16 halfwords and then
// issues 16 discarded fetches so the peripheral's 5-bit word counter
// returns to 0.
//  clk        in   clock, rising edge
//  rst        in   asynchronous active-high reset
//  start      in   request; block_in/last sampled when start & ready
//  last       in   final block of the message
//  block_in   in   512-bit block, word 0 = block_in[511:496]
//  ready      out  idle, accepts start
//  done       out  1-cycle pulse when a block is finished
//  digest     out  fetched hash, halfword k at digest[255-16k -: 16]
//  err        out  sticky handshake timeout flag
//  sha_load   out  peripheral load strobe
//  sha_fetch  out  peripheral fetch strobe
//  sha_wdata  out  peripheral write data
//  sha_rdata  in   peripheral read data
//  sha_ack    in   peripheral handshake acknowledge
//  core_busy  in   SHA core busy
module sha256_host_driver
  import sha256_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64,
  parameter int BUSY_SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         last,
  input  logic [511:0] block_in,
  output logic         ready,
  output logic         done,
  output logic [255:0] digest,
  output logic         err,
  output logic         sha_load,
  output logic         sha_fetch,
  output logic [15:0]  sha_wdata,
  input  logic [15:0]  sha_rdata,
  input  logic         sha_ack,
  input  logic         core_busy
);

  localparam logic [5:0] WCNT_END = 6'(WORDS_PER_BLOCK);
  localparam logic [5:0] FCNT_DIG = 6'(HALFWORDS_PER_DIGEST);
  localparam logic [5:0] FCNT_END = 6'(2 * HALFWORDS_PER_DIGEST);

  drv_state_t   state, state_d;
  logic [511:0] shreg;
  logic         last_q;
  logic [5:0]   wcnt;
  logic [5:0]   fcnt;
  logic         raln_gap, raln_gap_d;
  logic         tmo_load, tmo_en, tmo_expired;
  logic         settle_load, settle_en, settle_expired;

  // The word on the port is always the top of the shift register, so
  // it is stable from the load request until the ack shifts it out.
  assign sha_wdata = shreg[511:496];

  // Timeout runs in every state that waits on the peripheral or core
  assign tmo_en = (state == LD_REQ) || (state == LD_WAIT) ||
                  (state == FT_REQ) || (state == RALN);

  // Settle counter is armed by each load ack and drains in LD_WAIT
  assign settle_load = (state == LD_REQ) && sha_ack;
  assign settle_en   = (state == LD_WAIT);

  sha_hs_timeout #(.START(ACK_TIMEOUT - 1)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  sha_hs_timeout #(.START(BUSY_SETTLE)) u_settle (
    .clk     (clk),
    .rst     (rst),
    .load    (settle_load),
    .en      (settle_en),
    .expired (settle_expired)
  );

  // Next-state logic. An ack always beats a simultaneous timeout. In RALN
  // the raln_gap bit splits each discarded fetch into a request phase and
  // a one-cycle idle phase, mirroring FT_REQ/FT_GAP; the timeout restarts
  // at every new request as well as on every state change.
  always_comb begin
    state_d    = state;
    raln_gap_d = raln_gap;
    tmo_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && ready) state_d = LD_REQ;
      end
      LD_REQ: begin
        if (sha_ack)          state_d = LD_WAIT;
        else if (tmo_expired) state_d = ERR;
      end
      LD_WAIT: begin
        if (settle_expired && !core_busy) begin
          if (wcnt < WCNT_END) state_d = LD_REQ;
          else if (last_q)     state_d = FT_REQ;
          else                 state_d = FIN;
        end else if (tmo_expired) begin
          state_d = ERR;
        end
      end
      FT_REQ: begin
        if (sha_ack)          state_d = FT_GAP;
        else if (tmo_expired) state_d = ERR;
      end
      FT_GAP: begin
        raln_gap_d = 1'b0;
        if (fcnt < FCNT_DIG) state_d = FT_REQ;
        else                 state_d = RALN;
      end
      RALN: begin
        if (raln_gap) begin
          if (fcnt == FCNT_END) begin
            state_d = FIN;
          end else begin
            raln_gap_d = 1'b0;
            tmo_load   = 1'b1;
          end
        end else if (sha_ack) begin
          raln_gap_d = 1'b1;
        end else if (tmo_expired) begin
          state_d = ERR;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state) tmo_load = 1'b1;
  end

  // State register and the registered control outputs, all decoded from
  // the next state so every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      raln_gap  <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      sha_load  <= 1'b0;
      sha_fetch <= 1'b0;
    end else begin
      state     <= state_d;
      raln_gap  <= raln_gap_d;
      ready     <= (state_d == IDLE);
      done      <= (state_d == FIN);
      sha_load  <= (state_d == LD_REQ);
      sha_fetch <= (state_d == FT_REQ) || ((state_d == RALN) && !raln_gap_d);
      if (state_d == ERR) err <= 1'b1;
    end
  end

  // Datapath: block shift register, word/fetch counters and digest
  // capture. Discarded RALN fetches only advance fcnt, never digest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      last_q <= 1'b0;
      wcnt   <= '0;
      fcnt   <= '0;
      digest <= '0;
    end else begin
      if ((state == IDLE) && start && ready) begin
        shreg  <= block_in;
        last_q <= last;
        wcnt   <= '0;
      end
      if ((state == LD_REQ) && sha_ack) begin
        shreg <= {shreg[495:0], 16'h0000};
        wcnt  <= wcnt + 6'd1;
      end
      if ((state == LD_WAIT) && (state_d == FT_REQ)) begin
        fcnt <= '0;
      end
      if ((state == FT_REQ) && sha_ack) begin
        for (int k = 0; k < HALFWORDS_PER_DIGEST; k++) begin
          if (fcnt[3:0] == 4'(k)) digest[255-16*k -: 16] <= sha_rdata;
        end
        fcnt <= fcnt + 6'd1;
      end
      if ((state == RALN) && !raln_gap && sha_ack) begin
        fcnt <= fcnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_host_driver.sv
// Testbench for sha256_host_driver. A peripheral/core model answers the
// load/fetch handshakes (ack two cycles after the request), keeps a 5-bit
// word counter, and runs a software SHA-256 compression after every 32nd
// load. Expected digests come from the same software compression applied
// to the block sequence, plus the known SHA-256("abc") constant.
module tb_sha256_host_driver;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         last;
  logic [511:0] block_in;
  logic         ready;
  logic         done;
  logic [255:0] digest;
  logic         err;
  logic         sha_load;
  logic         sha_fetch;
  logic [15:0]  sha_wdata;
  logic [15:0]  sha_rdata;
  logic         sha_ack;
  logic         core_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_host_driver #(.ACK_TIMEOUT(64), .BUSY_SETTLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last      (last),
    .block_in  (block_in),
    .ready     (ready),
    .done      (done),
    .digest    (digest),
    .err       (err),
    .sha_load  (sha_load),
    .sha_fetch (sha_fetch),
    .sha_wdata (sha_wdata),
    .sha_rdata (sha_rdata),
    .sha_ack   (sha_ack),
    .core_busy (core_busy)
  );

  // SHA-256 software model
  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_EXP =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = $urandom;
    return r;
  endfunction

  // Peripheral + core model
  logic [4:0]   pcount;
  logic [511:0] pbuf;
  logic [255:0] hstate;
  int  lat, busy_cnt;
  bit  pend;
  int  loads_cnt = 0;
  int  fetch_cnt = 0;
  int  seen_seq  = 0;
  int  msg_seq   = 0;
  int  busy_len  = 0;
  int  withhold  = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pcount    = 5'd0;
      lat       = 0;
      pend      = 1'b0;
      busy_cnt  = 0;
      sha_ack   <= 1'b0;
      core_busy <= 1'b0;
      sha_rdata <= 16'h0000;
    end else begin
      int idx;
      sha_ack <= 1'b0;
      if (busy_cnt > 0) busy_cnt--;
      if (!sha_load && !sha_fetch) begin
        pend = 1'b0;
        lat  = 0;
      end else if (!pend && !(sha_load && (withhold == int'(pcount)))) begin
        lat++;
        if (lat >= 2) begin
          pend    = 1'b1;
          sha_ack <= 1'b1;
          if (sha_load) begin
            if ((pcount == 5'd0) && (seen_seq != msg_seq)) begin
              hstate   = IV;
              seen_seq = msg_seq;
            end
            idx = int'(pcount);
            pbuf[511-16*idx -: 16] = sha_wdata;
            if (pcount == 5'd31) hstate = sha_compress(hstate, pbuf);
            busy_cnt = busy_len;
            loads_cnt++;
          end else begin
            idx = int'(pcount[3:0]);
            sha_rdata <= hstate[255-16*idx -: 16];
            fetch_cnt++;
          end
          pcount = pcount + 5'd1;
        end
      end
      core_busy <= (busy_cnt != 0);
    end
  end

  // Output monitor: done pulses, load request pulses, loads raised while busy
  int   done_cnt  = 0;
  int   load_rise = 0;
  int   busy_viol = 0;
  logic prev_load = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if ((sha_load === 1'b1) && !prev_load) begin
      load_rise++;
      if (core_busy === 1'b1) busy_viol++;
    end
    prev_load = (sha_load === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [511:0] blk, input logic lst);
    start    = 1'b1;
    block_in = blk;
    last     = lst;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit got);
    int n = 0;
    while ((done !== 1'b1) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    got = (done === 1'b1);
  endtask

  // Waits for a fresh strobe whose preceding handshake count is idx
  task automatic waitRequest(input bit is_load, input int base, input int idx, output bit found);
    logic prev = 1'b1;
    logic cur;
    int   cnt;
    int   n = 0;
    found = 1'b0;
    while (!found && (n < 6000)) begin
      @(negedge clk);
      n++;
      cur = is_load ? sha_load : sha_fetch;
      cnt = is_load ? (loads_cnt - base) : (fetch_cnt - base);
      if ((cur === 1'b1) && !prev && (cnt == idx)) found = 1'b1;
      prev = (cur === 1'b1);
    end
  endtask

  task automatic runBlock(input string tag, input logic [511:0] blk, input logic lst,
                          input logic [255:0] exp_digest);
    int l0 = loads_cnt;
    int f0 = fetch_cnt;
    bit got;
    applyStimulus(blk, lst);
    waitDone(6000, got);
    checkOutput({tag, "_done"}, 256'(got), 256'(1));
    checkOutput({tag, "_digest"}, digest, exp_digest);
    checkOutput({tag, "_loads"}, 256'(loads_cnt - l0), 256'(32));
    checkOutput({tag, "_fetches"}, 256'(fetch_cnt - f0), lst ? 256'(32) : 256'(0));
    checkOutput({tag, "_pcount"}, 256'(pcount), 256'(0));
    checkOutput({tag, "_ready_fin"}, 256'(ready), 256'(0));
    @(negedge clk);
    checkOutput({tag, "_ready_after"}, 256'(ready), 256'(1));
    checkOutput({tag, "_done_pulse"}, 256'(done), 256'(0));
  endtask

  initial begin
    logic [255:0] h;
    logic [255:0] prev_digest;
    logic [511:0] b0, b1, b2;
    int  d0, l0, r0, v0, n;
    bit  got;

    rst      = 1'b1;
    start    = 1'b0;
    last     = 1'b0;
    block_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 256'(ready), 256'(1));
    checkOutput("rst_done", 256'(done), 256'(0));
    checkOutput("rst_err", 256'(err), 256'(0));
    checkOutput("rst_load", 256'(sha_load), 256'(0));
    checkOutput("rst_fetch", 256'(sha_fetch), 256'(0));
    checkOutput("rst_wdata", 256'(sha_wdata), 256'(0));
    checkOutput("rst_digest", digest, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] T1: abc single block");
    msg_seq++;
    runBlock("T1", ABC_BLOCK, 1'b1, ABC_EXP);
    prev_digest = ABC_EXP;

    $display("[TB] T2: two non-last blocks then a last block");
    msg_seq++;
    b0 = randBlock();
    b1 = randBlock();
    b2 = randBlock();
    h = sha_compress(IV, b0);
    runBlock("T2a", b0, 1'b0, prev_digest);
    h = sha_compress(h, b1);
    runBlock("T2b", b1, 1'b0, prev_digest);
    h = sha_compress(h, b2);
    runBlock("T2c", b2, 1'b1, h);
    prev_digest = h;

    $display("[TB] random single-block messages");
    for (int i = 0; i < 2; i++) begin
      busy_len = int'($urandom_range(0, 4));
      msg_seq++;
      b0 = randBlock();
      h  = sha_compress(IV, b0);
      runBlock("RND", b0, 1'b1, h);
    end

    $display("[TB] T3: core_busy held 20 cycles after each load");
    busy_len = 20;
    msg_seq++;
    b0 = randBlock();
    h  = sha_compress(IV, b0);
    r0 = load_rise;
    v0 = busy_viol;
    runBlock("T3", b0, 1'b1, h);
    checkOutput("T3_load_pulses", 256'(load_rise - r0), 256'(32));
    checkOutput("T3_load_while_busy", 256'(busy_viol - v0), 256'(0));
    busy_len = 0;

    $display("[TB] T6: start while busy and during done");
    msg_seq++;
    b0 = randBlock();
    h  = sha_compress(IV, b0);
    d0 = done_cnt;
    l0 = loads_cnt;
    applyStimulus(b0, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(randBlock(), 1'b0);
    waitDone(6000, got);
    checkOutput("T6_done", 256'(got), 256'(1));
    applyStimulus(randBlock(), 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("T6_one_done", 256'(done_cnt - d0), 256'(1));
    checkOutput("T6_loads", 256'(loads_cnt - l0), 256'(32));
    checkOutput("T6_digest", digest, h);
    checkOutput("T6_ready", 256'(ready), 256'(1));
    checkOutput("T6_no_load", 256'(sha_load), 256'(0));

    $display("[TB] T4: ack withheld on word 5");
    msg_seq++;
    withhold = 5;
    l0 = loads_cnt;
    applyStimulus(randBlock(), 1'b0);
    waitRequest(1'b1, l0, 5, got);
    checkOutput("T4_word5_req", 256'(got), 256'(1));
    n = 0;
    while ((err !== 1'b1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("T4_timeout_cycles", 256'(n), 256'(64));
    checkOutput("T4_load_dropped", 256'(sha_load), 256'(0));
    checkOutput("T4_ready", 256'(ready), 256'(0));
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    checkOutput("T4_err_sticky", 256'(err), 256'(1));
    checkOutput("T4_ready_held", 256'(ready), 256'(0));
    checkOutput("T4_no_done", 256'(done_cnt - d0), 256'(0));
    withhold = -1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("T4_err_cleared", 256'(err), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] T5: reset during fetch halfword 7");
    msg_seq++;
    l0 = fetch_cnt;
    applyStimulus(ABC_BLOCK, 1'b1);
    waitRequest(1'b0, l0, 7, got);
    checkOutput("T5_fetch7_req", 256'(got), 256'(1));
    #2 rst = 1'b1;
    #1;
    checkOutput("T5_ready", 256'(ready), 256'(1));
    checkOutput("T5_done", 256'(done), 256'(0));
    checkOutput("T5_err", 256'(err), 256'(0));
    checkOutput("T5_load", 256'(sha_load), 256'(0));
    checkOutput("T5_fetch", 256'(sha_fetch), 256'(0));
    checkOutput("T5_wdata", 256'(sha_wdata), 256'(0));
    checkOutput("T5_digest", digest, 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    msg_seq++;
    runBlock("T5re", ABC_BLOCK, 1'b1, ABC_EXP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
